// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory and sequences the
// label pass / execute pass, redirecting through a label table.
module instruction_fetch #(
  parameter int          PC_W       = 8,
  parameter int          NUM_LABELS = 16,
  parameter logic [7:0]  BUBBLE     = 8'hF0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  output logic [PC_W-1:0] program_counter,
  output logic [7:0]      instruction,
  output logic            labelPassFlag,
  input  logic            lbl_we,
  input  logic [3:0]      lbl_idx,
  input  logic [PC_W-1:0] lbl_value,
  input  logic            pc_reset,
  input  logic            halt,
  input  logic            br_taken,
  input  logic [3:0]      br_idx,
  output logic            squash,
  output logic            done,
  output logic            overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LABEL  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] label_table_r [NUM_LABELS];
  logic [PC_W-1:0] br_target_s;
  logic            table_clear_s;

  assign imem_addr     = pc_r;
  assign table_clear_s = (state_r == HALTED) && start;

  // Branch target with write-first bypass from a same-cycle label write.
  always_comb begin
    br_target_s = label_table_r[br_idx];
    if (lbl_we && (lbl_idx == br_idx)) begin
      br_target_s = lbl_value;
    end else begin
      br_target_s = label_table_r[br_idx];
    end
  end

  // Label table: cleared on reset and on restart from HALTED, else written by the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LABELS; i++) begin
        label_table_r[i] <= PC_ZERO;
      end
    end else if (table_clear_s) begin
      for (int i = 0; i < NUM_LABELS; i++) begin
        label_table_r[i] <= PC_ZERO;
      end
    end else if (lbl_we) begin
      label_table_r[lbl_idx] <= lbl_value;
    end
  end

  // Program flow FSM with all fetch outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      pc_r            <= PC_ZERO;
      program_counter <= PC_ZERO;
      instruction     <= BUBBLE;
      labelPassFlag   <= 1'b0;
      squash          <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      squash <= 1'b0;
      case (state_r)
        IDLE: begin
          instruction <= BUBBLE;
          if (start) begin
            state_r       <= LABEL;
            pc_r          <= PC_ZERO;
            labelPassFlag <= 1'b1;
          end
        end
        LABEL: begin
          if (pc_reset) begin
            state_r       <= EXEC;
            pc_r          <= PC_ZERO;
            labelPassFlag <= 1'b0;
            instruction   <= BUBBLE;
            squash        <= 1'b1;
          end else begin
            instruction     <= imem_rdata;
            program_counter <= pc_r;
            pc_r            <= pc_r + PC_ONE;
            if (&pc_r) begin
              overrun <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (halt) begin
            state_r     <= HALTED;
            instruction <= BUBBLE;
            done        <= 1'b1;
          end else if (br_taken) begin
            pc_r        <= br_target_s;
            instruction <= BUBBLE;
            squash      <= 1'b1;
          end else begin
            instruction     <= imem_rdata;
            program_counter <= pc_r;
            pc_r            <= pc_r + PC_ONE;
            if (&pc_r) begin
              overrun <= 1'b1;
            end
          end
        end
        HALTED: begin
          instruction <= BUBBLE;
          if (start) begin
            state_r       <= LABEL;
            pc_r          <= PC_ZERO;
            done          <= 1'b0;
            overrun       <= 1'b0;
            labelPassFlag <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          instruction   <= BUBBLE;
          labelPassFlag <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start, lbl_we, pc_reset, halt, br_taken;
  logic [3:0] lbl_idx, br_idx;
  logic [7:0] lbl_value;
  logic [7:0] imem_addr, imem_rdata, program_counter, instruction;
  logic       labelPassFlag, squash, done, overrun;

  logic [7:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  int n_checks = 0;
  int n_fails  = 0;

  // Model: 0 idle, 1 label pass, 2 execute, 3 halted
  int m_state, m_pc, m_pcq, m_instr;
  bit m_lpf, m_sq, m_done, m_ovr;
  int m_tab [16];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .program_counter(program_counter), .instruction(instruction),
    .labelPassFlag(labelPassFlag),
    .lbl_we(lbl_we), .lbl_idx(lbl_idx), .lbl_value(lbl_value),
    .pc_reset(pc_reset), .halt(halt), .br_taken(br_taken), .br_idx(br_idx),
    .squash(squash), .done(done), .overrun(overrun)
  );

  task automatic idle_inputs();
    start = 1'b0; lbl_we = 1'b0; pc_reset = 1'b0; halt = 1'b0; br_taken = 1'b0;
    lbl_idx = 4'd0; br_idx = 4'd0; lbl_value = 8'd0;
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_pcq = 0; m_instr = 'hF0;
    m_lpf = 0; m_sq = 0; m_done = 0; m_ovr = 0;
    for (int i = 0; i < 16; i++) m_tab[i] = 0;
  endtask

  task automatic model_fetch();
    m_instr = mem[m_pc];
    m_pcq   = m_pc;
    if (m_pc == 255) m_ovr = 1;
    m_pc = (m_pc + 1) % 256;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int target;
    bit clr;
    clr    = 0;
    target = (lbl_we && lbl_idx == br_idx) ? int'(lbl_value) : m_tab[br_idx];
    m_sq   = 0;
    case (m_state)
      0: begin
        m_instr = 'hF0;
        if (start) begin m_state = 1; m_pc = 0; m_lpf = 1; end
      end
      1: begin
        if (pc_reset) begin
          m_state = 2; m_pc = 0; m_lpf = 0; m_instr = 'hF0; m_sq = 1;
        end else model_fetch();
      end
      2: begin
        if (halt) begin
          m_state = 3; m_instr = 'hF0; m_done = 1;
        end else if (br_taken) begin
          m_pc = target; m_instr = 'hF0; m_sq = 1;
        end else model_fetch();
      end
      default: begin
        m_instr = 'hF0;
        if (start) begin
          m_state = 1; m_pc = 0; m_done = 0; m_ovr = 0; m_lpf = 1; clr = 1;
        end
      end
    endcase
    if (clr) for (int i = 0; i < 16; i++) m_tab[i] = 0;
    else if (lbl_we) m_tab[lbl_idx] = lbl_value;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int a);
    int n;
    n = 0;
    while (m_pc != a && n < 300) begin tick(); n++; end
    n_checks++;
    if (imem_addr !== 8'(a)) begin
      n_fails++;
      $display("FAIL advance_to: pc %h required %h", imem_addr, a);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    #10;
    n_checks++;
    if ({imem_addr, program_counter, instruction, labelPassFlag, squash, done, overrun}
        !== {8'h00, 8'h00, 8'hF0, 4'b0000}) begin
      n_fails++;
      $display("FAIL reset_state: got %h %h %h %b%b%b%b", imem_addr, program_counter,
               instruction, labelPassFlag, squash, done, overrun);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_label_pass();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (labelPassFlag !== 1'b1 || imem_addr !== 8'h00) begin
      n_fails++;
      $display("FAIL label_start: lpf %b pc %h required 1 00", labelPassFlag, imem_addr);
    end
    advance_to(2);
    lbl_we = 1'b1; lbl_idx = 4'd3; lbl_value = 8'h04; tick(); idle_inputs();
    advance_to(9);
    pc_reset = 1'b1; tick(); idle_inputs();
    n_checks++;
    if ({labelPassFlag, squash, imem_addr, instruction} !== {1'b0, 1'b1, 8'h00, 8'hF0}) begin
      n_fails++;
      $display("FAIL handover: lpf %b sq %b pc %h ins %h required 0 1 00 f0",
               labelPassFlag, squash, imem_addr, instruction);
    end
    tick();
    n_checks++;
    if ({squash, program_counter, instruction} !== {1'b0, 8'h00, mem[0]}) begin
      n_fails++;
      $display("FAIL handover_first: sq %b pcq %h ins %h required 0 00 %h",
               squash, program_counter, instruction, mem[0]);
    end
  endtask

  task automatic test_branch();
    advance_to(12);
    br_taken = 1'b1; br_idx = 4'd3; tick(); idle_inputs();
    n_checks++;
    if ({squash, imem_addr, instruction} !== {1'b1, 8'h04, 8'hF0}) begin
      n_fails++;
      $display("FAIL branch_redirect: sq %b pc %h ins %h required 1 04 f0",
               squash, imem_addr, instruction);
    end
    tick();
    n_checks++;
    if ({squash, program_counter, instruction} !== {1'b0, 8'h04, mem[4]}) begin
      n_fails++;
      $display("FAIL branch_target: sq %b pcq %h ins %h required 0 04 %h",
               squash, program_counter, instruction, mem[4]);
    end
  endtask

  task automatic test_bypass();
    tick();
    lbl_we = 1'b1; lbl_idx = 4'd2; lbl_value = 8'h20;
    br_taken = 1'b1; br_idx = 4'd2; tick(); idle_inputs();
    n_checks++;
    if (imem_addr !== 8'h20) begin
      n_fails++;
      $display("FAIL bypass: pc %h required 20", imem_addr);
    end
    tick();
    n_checks++;
    if ({program_counter, instruction} !== {8'h20, mem[8'h20]}) begin
      n_fails++;
      $display("FAIL bypass_fetch: pcq %h ins %h required 20 %h",
               program_counter, instruction, mem[8'h20]);
    end
  endtask

  task automatic test_halt_collision();
    logic [7:0] pc_hold, pcq_hold;
    tick(); tick();
    pc_hold  = 8'(m_pc);
    pcq_hold = 8'(m_pcq);
    halt = 1'b1; br_taken = 1'b1; br_idx = 4'd3; tick(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({done, squash, imem_addr, program_counter, instruction}
          !== {1'b1, 1'b0, pc_hold, pcq_hold, 8'hF0}) begin
        n_fails++;
        $display("FAIL halt_frozen[%0d]: done %b sq %b pc %h pcq %h ins %h required 1 0 %h %h f0",
                 i, done, squash, imem_addr, program_counter, instruction, pc_hold, pcq_hold);
      end
      br_taken = 1'($urandom); br_idx = 4'($urandom);
      pc_reset = 1'($urandom); halt = 1'($urandom);
      tick(); idle_inputs();
    end
    start = 1'b1; tick(); idle_inputs();
    n_checks++;
    if ({labelPassFlag, done, overrun, imem_addr, instruction}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 8'hF0}) begin
      n_fails++;
      $display("FAIL restart: lpf %b done %b ovr %b pc %h ins %h required 1 0 0 00 f0",
               labelPassFlag, done, overrun, imem_addr, instruction);
    end
  endtask

  task automatic test_wrap();
    advance_to(254);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fails++;
      $display("FAIL wrap_early: overrun %b required 0", overrun);
    end
    tick();
    tick();
    n_checks++;
    if ({imem_addr, overrun, program_counter} !== {8'h00, 1'b1, 8'hFF}) begin
      n_fails++;
      $display("FAIL wrap: pc %h ovr %b pcq %h required 00 1 ff",
               imem_addr, overrun, program_counter);
    end
    tick(); tick();
    n_checks++;
    if ({imem_addr, overrun, instruction} !== {8'h02, 1'b1, mem[1]}) begin
      n_fails++;
      $display("FAIL wrap_sticky: pc %h ovr %b ins %h required 02 1 %h",
               imem_addr, overrun, instruction, mem[1]);
    end
  endtask

  task automatic test_reset_mid_exec();
    int idx;
    pc_reset = 1'b1; tick(); idle_inputs();
    advance_to(5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({imem_addr, program_counter, instruction, labelPassFlag, done, squash}
        !== {8'h00, 8'h00, 8'hF0, 3'b000}) begin
      n_fails++;
      $display("FAIL reset_mid_exec: pc %h pcq %h ins %h lpf %b done %b sq %b",
               imem_addr, program_counter, instruction, labelPassFlag, done, squash);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; tick(); idle_inputs();
    advance_to(3);
    pc_reset = 1'b1; tick(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      advance_to(7);
      idx = (i == 0) ? 3 : (i == 1) ? 2 : int'($urandom_range(15, 0));
      br_taken = 1'b1; br_idx = 4'(idx); tick(); idle_inputs();
      n_checks++;
      if (imem_addr !== 8'h00) begin
        n_fails++;
        $display("FAIL table_cleared[%0d]: pc %h required 00", idx, imem_addr);
      end
    end
  endtask

  task automatic test_random();
    logic [27:0] act, exp_v;
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(99, 0) < 3);
      lbl_we   = ($urandom_range(99, 0) < 20);
      pc_reset = ($urandom_range(99, 0) < 4);
      halt     = ($urandom_range(99, 0) < 2);
      br_taken = ($urandom_range(99, 0) < 12);
      lbl_idx  = 4'($urandom_range(3, 0));
      br_idx   = 4'($urandom_range(3, 0));
      lbl_value = 8'($urandom);
      tick();
      act   = {imem_addr, program_counter, instruction, labelPassFlag, squash, done, overrun};
      exp_v = {8'(m_pc), 8'(m_pcq), 8'(m_instr), m_lpf, m_sq, m_done, m_ovr};
      n_checks++;
      if (act !== exp_v) begin
        n_fails++;
        $display("FAIL random[%0d]: got %h required %h", c, act, exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_label_pass();
    test_branch();
    test_bypass();
    test_halt_collision();
    test_wrap();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder. It owns the program counter, reads the 8-bit instruction memory, and runs the two-pass program flow.
- Pass 1 (label pass) scans the program and records each label's PC. Pass 2 (execute) runs from PC 0 and takes branches through the recorded label table.
- Its outputs feed the decoder's program_counter, instruction and labelPassFlagIn inputs. It consumes the decoder's labelFlag, labelValue, rd, outputPCResetFlag and haltFlag, plus the ALU's branch resolution.

Parameters:
- PC_W, 8, program counter / instruction address width.
- NUM_LABELS, 16, label table entries, indexed by the 4-bit rd.
- BUBBLE, 8'hF0, instruction injected for idle/squash (opcode 1111, no side effects).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins the label pass.
- imem_addr  out  PC_W  instruction memory address (= pc register, combinational read).
- imem_rdata  in  8  instruction memory data, valid the same cycle.
- program_counter  out  PC_W  PC of the instruction in the instruction register.
- instruction  out  8  registered instruction to the decoder.
- labelPassFlag  out  1  high throughout the label pass.
- lbl_we  in  1  decoder labelFlag.
- lbl_idx  in  4  decoder rd.
- lbl_value  in  PC_W  decoder labelValue.
- pc_reset  in  1  decoder outputPCResetFlag (halt seen during label pass).
- halt  in  1  decoder haltFlag (halt during execute).
- br_taken  in  1  ALU: blt condition true, qualified by branchFlag.
- br_idx  in  4  label index of the taken branch.
- squash  out  1  one-cycle pulse telling decode/execute to discard their current instruction.
- done  out  1  high in HALTED.
- overrun  out  1  sticky; PC wrapped past 2^PC_W-1 without a halt.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=0, program_counter=0, instruction=BUBBLE.
  - labelPassFlag=0, squash=0, done=0, overrun=0.
  - All label table entries cleared to 0.
- State IDLE:
  - instruction=BUBBLE, pc held.
  - start moves to LABEL on the next edge, with pc=0 and labelPassFlag=1.
- State LABEL and state EXEC, normal fetch, each edge:
  - instruction <= imem_rdata.
  - program_counter <= pc.
  - pc <= pc+1, modulo 2^PC_W.
  - The increment from all-ones to 0 sets overrun and keeps fetching.
- Label write:
  - When lbl_we=1 in any state, table[lbl_idx] <= lbl_value.
  - Last write to an index wins.
- LABEL to EXEC, on pc_reset:
  - pc <= 0, labelPassFlag <= 0, instruction <= BUBBLE, squash pulses for 1 cycle.
  - Label table is retained.
- EXEC, taken branch (br_taken=1):
  - pc <= table[br_idx], instruction <= BUBBLE, squash pulses for 1 cycle.
  - If lbl_we writes the same index in the same cycle, the new lbl_value is used (write-first bypass).
- EXEC, halt:
  - Next state is HALTED, instruction <= BUBBLE, done=1.
  - pc and program_counter freeze; later inputs are ignored except start.
- HALTED:
  - start returns to LABEL: pc=0, done=0, overrun=0.
  - The table is cleared in that same cycle.
- Priority when events coincide: halt > pc_reset > br_taken > normal fetch.
  - pc_reset is only honoured in LABEL; halt and br_taken only in EXEC.
  - In other states they are ignored.
- start while in LABEL or EXEC is ignored.
- Latency:
  - Instruction at address A appears on instruction one cycle after pc=A.
  - Redirect (branch or pass change): the instruction at the target appears 2 cycles after the redirecting input is sampled. One BUBBLE sits between.
- squash is combinationally independent of inputs; it is a registered pulse only.

Test Plan:
1. Reset mid-execute: assert rst_n=0 in EXEC with pc=0x05 -> immediately state=IDLE, pc=0, instruction=0xF0, done=0, labelPassFlag=0. All table entries read 0.
2. Label pass handover:
   - Stimulus: start, lbl_we with idx=3 value=0x04, then pc_reset at pc=0x09.
   - Required: labelPassFlag drops the following edge, pc=0, one BUBBLE on instruction, squash high one cycle, table[3]=0x04.
3. Taken branch in EXEC: table[3]=0x04, br_taken=1 with br_idx=3 at pc=0x0C -> next instruction=0xF0, squash=1, next pc=0x04. imem[0x04] appears one cycle later with program_counter=0x04.
4. Branch/label bypass: same cycle lbl_we idx=2 value=0x20 and br_taken br_idx=2 -> pc=0x20.
5. Halt vs branch collision: halt=1 and br_taken=1 in the same EXEC cycle -> HALTED, done=1, pc frozen (no redirect), instruction stays 0xF0. A later start restarts the label pass from 0 with done=0.
6. Wrap: run LABEL with no halt from pc=0xFE -> pc goes 0xFF, 0x00, overrun=1 and stays set; fetch continues.
